// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: valid/grant/rvalid data-memory handshake with size extension
module lsu (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state, state_nx;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        legal;
    logic [3:0]  be_nx;
    logic [31:0] wdata_nx;
    logic [31:0] sh;
    logic [31:0] ldval;

    always_comb begin
        legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b100: legal = 1'b1;
            3'b001, 3'b101: legal = ~req_addr[0];
            3'b010:         legal = (req_addr[1:0] == 2'b00);
            default:        legal = 1'b0;
        endcase
        // unsigned variants exist only for loads
        if (req_we && req_funct3[2])
            legal = 1'b0;
    end

    always_comb begin
        be_nx    = 4'b1111;
        wdata_nx = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                be_nx    = 4'b0001 << req_addr[1:0];
                wdata_nx = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_nx    = 4'b0011 << req_addr[1:0];
                wdata_nx = {2{req_wdata[15:0]}};
            end
            default: begin
                be_nx    = 4'b1111;
                wdata_nx = req_wdata;
            end
        endcase
    end

    always_comb begin
        sh    = mem_rdata >> {off_q, 3'b000};
        ldval = mem_rdata;
        case (f3_q)
            3'b000:  ldval = {{24{sh[7]}}, sh[7:0]};
            3'b100:  ldval = {24'h0, sh[7:0]};
            3'b001:  ldval = {{16{sh[15]}}, sh[15:0]};
            3'b101:  ldval = {16'h0, sh[15:0]};
            default: ldval = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
            rdata     <= 32'h0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && req_valid && legal) begin
                we_q      <= req_we;
                f3_q      <= req_funct3;
                off_q     <= req_addr[1:0];
                mem_addr  <= {req_addr[31:2], 2'b00};
                mem_be    <= be_nx;
                mem_wdata <= wdata_nx;
            end
            if (state == S_WAIT && mem_rvalid)
                rdata <= ldval;
        end
    end

    always_comb begin
        state_nx = state;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid)
                    state_nx = legal ? S_REQ : S_ERR;
            end
            S_REQ: begin
                mem_req = 1'b1;
                mem_we  = we_q;
                if (mem_gnt)
                    state_nx = we_q ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid)
                    state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            S_ERR: begin
                err      = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy = req_valid & ~done & ~err;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for lsu: directed vectors, reset cases, randomized ops vs model
module tb_lsu;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        busy, done, err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] last_rdata = 32'h0;

    lsu dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit m_legal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 0;
        if (we && (f3 == 3'd4 || f3 == 3'd5)) return 0;
        return (addr % nbytes(f3)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
        int n = nbytes(f3);
        int v = ((1 << n) - 1) << (addr % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int n = nbytes(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] w);
        int n = nbytes(f3);
        longint v;
        if (n == 4) return w;
        v = (longint'(w) >> (8 * (addr % 4))) & ((longint'(1) << (8 * n)) - 1);
        if (!f3[2] && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    // Acts as both the core and the data memory for one operation; accept cycle is c=0.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                          input int gd, input int rd, input logic [31:0] mword,
                          input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
        int c = 0, reqcnt = 0, since = 0;
        bit granted = 0, finished = 0;
        @(posedge clk); #1;
        check("idle_no_pulse", {30'h0, done, err}, 32'h0);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        check("busy_accept", busy, 1);
        while (!finished && c < 200) begin
            @(posedge clk); #1;
            c++;
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (done || err) begin
                finished = 1;
                check("latency", c, exp_lat);
                check("err", err, exp_err);
                check("done", done, !exp_err);
                check("busy_end", busy, 0);
                check("req_at_end", mem_req, 0);
                if (!exp_err && !we) last_rdata = exp_rdata;
                check("rdata", rdata, last_rdata);
                req_valid = 1'b0;
            end else begin
                check("busy", busy, 1);
                if (exp_err) check("no_mem_req", mem_req, 0);
                if (mem_req) begin
                    check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
                    check("mem_be", {28'h0, mem_be}, {28'h0, exp_be});
                    check("mem_wdata", mem_wdata, exp_wd);
                    check("mem_we", mem_we, we);
                    if (reqcnt == gd) begin
                        mem_gnt = 1'b1; granted = 1;
                    end else reqcnt++;
                end else if (granted) begin
                    since++;
                    if (since == rd) begin
                        mem_rvalid = 1'b1; mem_rdata = mword;
                    end
                end
            end
        end
        if (!finished) check("timeout", 0, 1);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        int          gd;
        int          rd;
        logic [31:0] mword;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{1'b1, 3'b010, 32'h0000_1004, 32'hDEADBEEF, 0, 1, 32'h0, 1'b0, 32'h0, 2, 4'b1111, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 1, 32'h0, 1'b0, 32'h0, 2, 4'b1000, 32'hA5A5A5A5};
        vecs[2]  = '{1'b0, 3'b000, 32'h0000_1001, 32'h0, 0, 1, 32'h8070F0FF, 1'b0, 32'hFFFFFFF0, 3, 4'b0010, 32'h0};
        vecs[3]  = '{1'b0, 3'b100, 32'h0000_1001, 32'h0, 0, 1, 32'h8070F0FF, 1'b0, 32'h000000F0, 3, 4'b0010, 32'h0};
        vecs[4]  = '{1'b0, 3'b001, 32'h0000_1002, 32'h0, 0, 1, 32'h8070F0FF, 1'b0, 32'hFFFF8070, 3, 4'b1100, 32'h0};
        vecs[5]  = '{1'b0, 3'b101, 32'h0000_1002, 32'h0, 0, 1, 32'h8070F0FF, 1'b0, 32'h00008070, 3, 4'b1100, 32'h0};
        vecs[6]  = '{1'b0, 3'b010, 32'h0000_1000, 32'h0, 5, 3, 32'h8070F0FF, 1'b0, 32'h8070F0FF, 10, 4'b1111, 32'h0};
        vecs[7]  = '{1'b0, 3'b001, 32'h0000_1001, 32'h0, 0, 1, 32'h0, 1'b1, 32'h0, 1, 4'b0000, 32'h0};
        vecs[8]  = '{1'b1, 3'b010, 32'h0000_1002, 32'h12345678, 0, 1, 32'h0, 1'b1, 32'h0, 1, 4'b0000, 32'h0};
        vecs[9]  = '{1'b1, 3'b100, 32'h0000_1000, 32'h12345678, 0, 1, 32'h0, 1'b1, 32'h0, 1, 4'b0000, 32'h0};
        vecs[10] = '{1'b0, 3'b011, 32'h0000_1000, 32'h0, 0, 1, 32'h0, 1'b1, 32'h0, 1, 4'b0000, 32'h0};

        #12;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_done_err", {30'h0, done, err}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_be", {28'h0, mem_be}, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, vecs[i].gd, vecs[i].rd, vecs[i].mword,
                   vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].exp_lat, vecs[i].exp_be, vecs[i].exp_wd);

        // reset while a store waits for grant: mem_req must drop asynchronously
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h3000; req_wdata = 32'h11223344;
        @(posedge clk); #1;
        check("req_before_rst", mem_req, 1);
        #2 rstn = 1'b0;
        #1;
        check("rst_req_drop", mem_req, 0);
        check("rst_req_be", {28'h0, mem_be}, 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1; req_valid = 1'b0;

        // reset during WAIT, then a stray rvalid
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h2000;
        @(posedge clk); #1;
        check("wait_req", mem_req, 1);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        check("wait_no_done", done, 0);
        #2 rstn = 1'b0;
        #1;
        check("rst_wait_req", mem_req, 0);
        check("rst_wait_rdata", rdata, 32'h0);
        check("rst_wait_done", done, 0);
        @(posedge clk); #1;
        rstn = 1'b1; req_valid = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("late_rvalid_done", done, 0);
            check("late_rvalid_rdata", rdata, 32'h0);
            @(posedge clk); #1;
        end
        last_rdata = 32'h0;
        run_op(1'b1, 3'b010, 32'h0000_4008, 32'h0BADF00D, 0, 1, 32'h0, 1'b0, 32'h0, 2, 4'b1111, 32'h0BADF00D);

        for (int t = 0; t < 60; t++) begin
            logic        we = 1'($urandom_range(0, 1));
            logic [2:0]  f3 = 3'($urandom_range(0, 7));
            logic [31:0] a = $urandom;
            logic [31:0] wd = $urandom;
            logic [31:0] mw = $urandom;
            int          gd = $urandom_range(0, 3);
            int          rd = $urandom_range(1, 3);
            bit          ok = m_legal(we, f3, a);
            int          lat = !ok ? 1 : (we ? gd + 2 : gd + rd + 2);
            run_op(we, f3, a, wd, gd, rd, mw, !ok, m_load(f3, a, mw), lat, m_be(f3, a), m_wdata(f3, wd));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the single-cycle RISC-V core. It sits directly downstream of the ALU: it takes the ALU result C as the effective address of a load/store, plus rs2 as store data. It runs a valid/grant/rvalid handshake with the data memory and returns a size-extended load value to the write-back mux. While the access is in flight it stalls the core.

## Interface
- No parameters; address and data are fixed at 32 bits.
- clk  in  1  core clock, rising edge
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  core requests a memory op; held high until done or err
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  in  32  byte address (ALU result C)
- req_wdata  in  32  store data (rs2)
- busy  out  1  stall to core
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle misalign/illegal pulse
- rdata  out  32  extended load result, valid while done=1 and held until next load completes
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  32  word address, {req_addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  memory accepted request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

## Operation
- FSM states:
  - IDLE: accepts a request.
  - REQ: drives mem_req.
  - WAIT: waits for load data.
  - DONE: pulses done.
  - ERR: pulses err.
- IDLE, req_valid=1:
  - Legality check first. Illegal cases: h/hu with addr[0]=1; w with addr[1:0]≠0; funct3 ∈ {011,110,111}; store with funct3 100 or 101. Illegal → ERR.
  - Otherwise latch we, funct3, addr[1:0], mem_addr, mem_be and mem_wdata into registers → REQ.
- REQ:
  - mem_req=1; all mem_* outputs come from registers and are stable until grant.
  - mem_gnt=1 → DONE for a store, WAIT for a load.
  - mem_gnt=0 → stay in REQ; no timeout.
- WAIT: mem_rvalid=1 → capture the extended value into rdata → DONE. mem_rvalid is ignored in every other state.
- DONE: done=1 → IDLE. ERR: err=1 → IDLE. req_valid is ignored in both, so the core must drop or change it after the pulse.
- Byte enables, with o=addr[1:0]:
  - b: 4'b0001<<o
  - h: 4'b0011<<o
  - w: 4'b1111
- Store data:
  - b: {4{wdata[7:0]}}
  - h: {2{wdata[15:0]}}
  - w: wdata
- Load extraction:
  - sh = mem_rdata >> (8*o).
  - lb/lh sign-extend sh[7:0]/sh[15:0]; lbu/lhu zero-extend; lw takes mem_rdata.
- busy = req_valid & ~done & ~err (combinational). The core therefore stalls from the accept cycle through the cycle before done.

## Timing
- Reset (async, rstn=0):
  - State → IDLE.
  - mem_req, mem_we, done, err = 0.
  - mem_addr, mem_be, mem_wdata, rdata = 0.
  - Takes effect immediately, including mid-REQ/WAIT. mem_req drops without waiting for clk; any later rvalid is ignored.
- Store with same-cycle grant: accept cycle T, mem_req in T+1, done in T+2. Total 3 cycles.
- Load with rvalid one cycle after grant: T accept, T+1 grant, T+2 rvalid, T+3 done/rdata. Total 4 cycles.
- Misaligned/illegal: T accept, err in T+1, no mem_req ever asserted.
- Back-to-back: earliest next accept is the cycle after DONE/ERR.
- mem_rvalid in the same cycle as mem_gnt is not supported; the memory must return data ≥1 cycle after grant.

## Test plan
- Store words:
  - sw addr=0x0000_1004, wdata=0xDEADBEEF, gnt immediate → mem_addr=0x1004, mem_be=1111, mem_wdata=0xDEADBEEF, mem_we=1, done at T+2.
- Store byte:
  - sb addr=0x1003, wdata=0x000000A5 → mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x1000.
- Load byte/halfword extension, mem_rdata=0x8070_F0FF:
  - lb @+1 → 0xFFFFFFF0
  - lbu @+1 → 0x000000F0
  - lh @+2 → 0xFFFF8070
  - lhu @+2 → 0x00008070
  - lw @+0 → 0x8070F0FF
- Grant stall:
  - lw with mem_gnt held low 5 cycles, rvalid 3 cycles after grant → mem_* outputs stable throughout, busy=1 every cycle, done exactly once, total latency 11 cycles.
- Errors:
  - lh addr=0x1001 → err pulse at T+1, mem_req never 1.
  - sw addr=0x1002 → err.
  - store funct3=100 → err.
  - funct3=011 → err.
- Reset mid-op:
  - rstn low during WAIT → mem_req=0, rdata=0, done=0 immediately.
  - Late rvalid after release → no done.
  - Following sw completes normally in 3 cycles.
